// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between the CPU fetch
// port and the program loader. Fetch gets 1-cycle-latency registered responses;
// out-of-range or misaligned accesses are flagged and never touch memory.
// Optional boot sweep that zeroes the memory after reset: macro IMEM_BOOT_CLEAR_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | sweep memory: write 0 to every word, one per cycle (busy=1)
// S_RUN   | arbitrate fetch vs. load, alternating under contention
module imem_arbiter #(
  parameter int MEM_SIZE = 256,
  parameter int AW       = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          fetch_valid,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_ready,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          load_valid,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          load_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {G_FETCH, G_LOAD} grant_t;

  grant_t        r_last_grant;
  logic          r_fetch_rvalid;
  logic [31:0]   r_fetch_rdata;
  logic          r_fetch_err;
  logic          r_load_err;

  logic          w_clear;
  logic [AW-1:0] w_clr_addr;
  logic          w_grant_f;
  logic          w_grant_l;
  logic          w_fetch_bad;
  logic          w_load_bad;

`ifdef IMEM_BOOT_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;

  // State register and sweep counter; reset restarts the sweep from word 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + AW'(1);
    end
  end

  // Leave the sweep after the last word has been written.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && r_clr_cnt == AW'(MEM_SIZE - 1)) w_state_nxt = S_RUN;
  end

  assign w_clear    = (r_state == S_CLEAR);
  assign w_clr_addr = r_clr_cnt;
`else
  assign w_clear    = 1'b0;
  assign w_clr_addr = '0;
`endif

  // Word index beyond the memory or a non-word-aligned byte address.
  assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) || ({2'b00, fetch_addr[31:2]} >= 32'(MEM_SIZE));
  assign w_load_bad  = (load_addr[1:0]  != 2'b00) || ({2'b00, load_addr[31:2]}  >= 32'(MEM_SIZE));

  // Loader wins a tie only when fetch had the previous grant.
  assign w_grant_l = !w_clear && load_valid && (!fetch_valid || r_last_grant == G_FETCH);
  assign w_grant_f = !w_clear && fetch_valid && !w_grant_l;

  // Memory port mux and handshake outputs.
  always_comb begin
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b0;
    if (w_clear) begin
      mem_we   = 1'b1;
      mem_addr = w_clr_addr;
      busy     = 1'b1;
    end else if (w_grant_l) begin
      load_ready = 1'b1;
      mem_addr   = load_addr[AW+1:2];
      mem_wdata  = load_data;
      mem_we     = !w_load_bad;
    end else if (w_grant_f) begin
      fetch_ready = 1'b1;
      mem_addr    = fetch_addr[AW+1:2];
    end
  end

  // Grant history; idle cycles leave it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= G_FETCH;
    end else if (w_grant_l) begin
      r_last_grant <= G_LOAD;
    end else if (w_grant_f) begin
      r_last_grant <= G_FETCH;
    end
  end

  // Registered fetch response and load error pulse, one cycle after acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_rvalid <= 1'b0;
      r_fetch_rdata  <= '0;
      r_fetch_err    <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_fetch_rvalid <= w_grant_f;
      r_fetch_err    <= w_grant_f && w_fetch_bad;
      r_load_err     <= w_grant_l && w_load_bad;
      if (w_grant_f) r_fetch_rdata <= w_fetch_bad ? NOP_INSN : mem_rdata;
    end
  end

  assign fetch_rvalid = r_fetch_rvalid;
  assign fetch_rdata  = r_fetch_rdata;
  assign fetch_err    = r_fetch_err;
  assign load_err     = r_load_err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter (MEM_SIZE=256) with a behavioural memory model.
// Follows IMEM_BOOT_CLEAR_EN the same way the design does.
module tb_imem_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          fetch_valid, load_valid;
  logic [31:0]   fetch_addr, load_addr, load_data;
  logic          fetch_ready, fetch_rvalid, fetch_err, load_ready, load_err;
  logic [31:0]   fetch_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, busy;

  imem_arbiter #(.MEM_SIZE(256)) dut (
    .clk(clk), .resetn(resetn),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_err(load_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] data; logic err; } fexp_t;
  typedef struct { int due; logic err; } lexp_t;
  fexp_t fq[$];
  lexp_t lq[$];
  fexp_t fe;
  lexp_t le;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: responses must appear exactly in their due cycle.
  always @(negedge clk) begin
    if (fq.size() > 0 && fq[0].due == cyc) begin
      fe = fq.pop_front();
      chk("fetch_rvalid", {31'b0, fetch_rvalid}, 32'd1);
      chk("fetch_rdata", fetch_rdata, fe.data);
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, fe.err});
    end else begin
      chk("fetch_rvalid idle", {31'b0, fetch_rvalid}, 32'd0);
      chk("fetch_err idle", {31'b0, fetch_err}, 32'd0);
    end
    if (lq.size() > 0 && lq[0].due == cyc) begin
      le = lq.pop_front();
      chk("load_err", {31'b0, load_err}, {31'b0, le.err});
    end else begin
      chk("load_err idle", {31'b0, load_err}, 32'd0);
    end
  end

  task automatic drv(input logic fv, input logic [31:0] fa, input logic lv,
                     input logic [31:0] la, input logic [31:0] ld);
    fetch_valid = fv; fetch_addr = fa;
    load_valid = lv; load_addr = la; load_data = ld;
  endtask

  // One RUN cycle: check grant and memory port, queue the expected responses.
  task automatic step(input string nm, input logic efr, input logic elr, input logic ewe,
                      input logic [AW-1:0] eaddr, input logic cwd, input logic [31:0] ewd,
                      input logic [31:0] frd, input logic fer, input logic ler);
    @(negedge clk);
    chk({nm, " fetch_ready"}, {31'b0, fetch_ready}, {31'b0, efr});
    chk({nm, " load_ready"}, {31'b0, load_ready}, {31'b0, elr});
    chk({nm, " mem_we"}, {31'b0, mem_we}, {31'b0, ewe});
    chk({nm, " mem_addr"}, {24'b0, mem_addr}, {24'b0, eaddr});
    if (cwd) chk({nm, " mem_wdata"}, mem_wdata, ewd);
    chk({nm, " busy"}, {31'b0, busy}, 32'd0);
    if (efr) fq.push_back('{cyc + 1, frd, fer});
    if (elr) lq.push_back('{cyc + 1, ler});
    @(posedge clk); #1;
  endtask

`ifdef IMEM_BOOT_CLEAR_EN
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("sweep busy", {31'b0, busy}, 32'd1);
      chk("sweep mem_we", {31'b0, mem_we}, 32'd1);
      chk("sweep mem_addr", {24'b0, mem_addr}, i);
      chk("sweep mem_wdata", mem_wdata, 32'd0);
      chk("sweep readys", {30'b0, fetch_ready, load_ready}, 32'd0);
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    drv(1'b1, 32'h20, 1'b1, 32'h20, 32'h1111_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst fetch_rvalid", {31'b0, fetch_rvalid}, 32'd0);
    chk("rst fetch_rdata", fetch_rdata, 32'd0);
    chk("rst fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst load_err", {31'b0, load_err}, 32'd0);
`ifdef IMEM_BOOT_CLEAR_EN
    chk("rst busy", {31'b0, busy}, 32'd1);
    chk("rst mem_addr", {24'b0, mem_addr}, 32'd0);
`else
    chk("rst busy", {31'b0, busy}, 32'd0);
`endif
    @(posedge clk); #1;
    resetn = 1'b1;
`ifdef IMEM_BOOT_CLEAR_EN
    sweep(256);
`endif

    // Contention from the first RUN cycle: L,F,L,F,L,F; each fetch sees the prior write.
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 32'h20, 1'b1, 32'h20, 32'h1111_0000 + i);
      if (i % 2 == 0)
        step("contend L", 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 32'h1111_0000 + i, 32'h0, 1'b0, 1'b0);
      else
        step("contend F", 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 32'h0, 32'h1111_0000 + i - 1, 1'b0, 1'b0);
    end

    drv(1'b0, 32'h0, 1'b1, 32'h8, 32'h0050_0093);
    step("load 0x8", 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    drv(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step("fetch 0x8", 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    drv(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    step("fetch 0x20", 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 32'h0, 32'h1111_0004, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h3FC, 32'hCAFE_F00D);
    step("load 0x3fc", 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    drv(1'b1, 32'h3FC, 1'b0, 32'h0, 32'h0);
    step("fetch 0x3fc", 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    drv(1'b1, 32'h400, 1'b0, 32'h0, 32'h0);
    step("fetch 0x400", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0000_0013, 1'b1, 1'b0);
    drv(1'b1, 32'h6, 1'b0, 32'h0, 32'h0);
    step("fetch 0x6", 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 32'h0, 32'h0000_0013, 1'b1, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h400, 32'hDEAD_BEEF);
    step("load 0x400", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b1, 32'h6, 32'hDEAD_BEEF);
    step("load 0x6", 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    step("idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    drv(1'b1, 32'h8, 1'b1, 32'h10, 32'h0BAD_BEEF);
    step("tie after L", 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    step("tie after F", 1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 32'h0BAD_BEEF, 32'h0, 1'b0, 1'b0);
    drv(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    step("fetch 0x10", 1'b1, 1'b0, 1'b0, 8'h04, 1'b0, 32'h0, 32'h0BAD_BEEF, 1'b0, 1'b0);

    // Reset while a fetch response is due: the response must be dropped.
    drv(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("pending fetch_ready", {31'b0, fetch_ready}, 32'd1);
    #1;
    resetn = 1'b0;
    fq.delete();
    lq.delete();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("dropped fetch_rvalid", {31'b0, fetch_rvalid}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
`ifdef IMEM_BOOT_CLEAR_EN
    sweep(100);
    resetn = 1'b0;
    #1;
    chk("midsweep rst mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("midsweep rst busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    sweep(256);
    drv(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step("fetch cleared", 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`else
    drv(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step("fetch kept", 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
`endif
    drv(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", fq.size() + lq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 256: instruction memory depth in 32-bit words, power of two, 2..65536.
REQ-002 Parameter AW, default $clog2(MEM_SIZE): width of the memory word index.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 fetch_valid  input  1  CPU fetch request.
REQ-006 fetch_addr  input  32  CPU byte address.
REQ-007 fetch_ready  output  1  fetch request accepted this cycle.
REQ-008 fetch_rvalid  output  1  fetch response valid.
REQ-009 fetch_rdata  output  32  fetched instruction word.
REQ-010 fetch_err  output  1  the fetch response is out of range or misaligned.
REQ-011 load_valid  input  1  program-loader write request.
REQ-012 load_addr  input  32  loader byte address.
REQ-013 load_data  input  32  loader write data.
REQ-014 load_ready  output  1  load request accepted this cycle.
REQ-015 load_err  output  1  registered pulse: the accepted load was out of range or misaligned.
REQ-016 mem_addr  output  AW  memory word index.
REQ-017 mem_we  output  1  memory write enable, sampled by the memory on rising clk.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  combinational read data for mem_addr.
REQ-020 busy  output  1  high while in CLEAR state.

Function
REQ-021 The FSM has the states CLEAR (sweep memory) and RUN (arbitrate).
REQ-022 In CLEAR: mem_we=1, mem_wdata=0, mem_addr=clr_cnt; clr_cnt increments by one per cycle from 0; the FSM moves to RUN after the cycle with clr_cnt=MEM_SIZE-1 (MEM_SIZE cycles total).
REQ-023 In CLEAR: fetch_ready=0, load_ready=0, busy=1.
REQ-024 In RUN: at most one requester is granted per cycle; ready is combinational from state, valids and last_grant.
REQ-025 With only one valid, that requester is granted.
REQ-026 With both valid: the loader wins if last_grant=FETCH; otherwise fetch wins.
REQ-027 last_grant updates on every grant (strict alternation under continuous contention); it is not updated on idle cycles.
REQ-028 Fetch grant: mem_addr=fetch_addr[AW+1:2], mem_we=0.
REQ-029 Fetch response: fetch_rvalid=1 exactly one cycle after acceptance, with fetch_rdata=mem_rdata registered at acceptance; 1-cycle latency, back-to-back fetches each cycle supported.
REQ-030 An accepted fetch with fetch_addr[1:0]!=0 or fetch_addr[31:2]>=MEM_SIZE returns fetch_rdata=32'h00000013 (NOP) and fetch_err=1 on the response cycle.
REQ-031 Load grant: mem_addr=load_addr[AW+1:2], mem_wdata=load_data, mem_we=1 in the same cycle.
REQ-032 An out-of-range or misaligned accepted load is consumed with mem_we=0 and sets load_err=1 on the next cycle.
REQ-033 No grant in RUN: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 fetch_rvalid, fetch_err and load_err are single-cycle pulses and are low whenever no response is due.
REQ-035 A fetch to the address being written by the loader in the previous cycle returns the new data.

Reset
REQ-036 resetn low asynchronously forces: state=CLEAR (RUN if the macro is absent), clr_cnt=0, last_grant=FETCH, fetch_rvalid=0, fetch_rdata=0, fetch_err=0, load_err=0.
REQ-037 A reset asserted mid-sweep or with a fetch response pending discards the sweep or response; after release the sweep restarts at 0.

Configuration
REQ-038 Macro IMEM_BOOT_CLEAR_EN defined: the CLEAR state exists and reset enters it.
REQ-039 IMEM_BOOT_CLEAR_EN undefined: no CLEAR state and no clr_cnt; reset enters RUN directly; busy is tied to 0; memory contents are untouched by reset.

Verification
REQ-040 Reset release, macro defined, MEM_SIZE=256 -> busy=1 for 256 cycles, mem_we=1 with addresses 0..255 and data 0, then ready asserts.
REQ-041 Load 0x00500093 at addr 0x8, then fetch addr 0x8 -> fetch_rvalid one cycle later with fetch_rdata=0x00500093, fetch_err=0.
REQ-042 Both valid for 6 cycles from reset -> grant order L,F,L,F,L,F; no cycle with both readys high.
REQ-043 Fetch addr 0x400 (MEM_SIZE=256) and fetch addr 0x6 -> each returns 0x00000013 with fetch_err=1; load addr 0x400 -> mem_we=0, load_err=1 next cycle.
REQ-044 resetn pulsed low at sweep cycle 100 and with fetch_rvalid due -> fetch_rvalid stays 0 and the sweep restarts at mem_addr 0.
REQ-045 Macro undefined -> ready is high on the first cycle after reset release and busy=0 throughout.
